// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } rx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver with mid-bit sampling; 8N1 by default, 8E1/8O1 when
// UART_RX_PARITY_EN is defined.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             w_rx_s;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             w_mid;
  logic             w_bit_end;
  logic             w_par_err;
  logic             r_dv;
  logic [7:0]       r_byte;
  logic             r_frame_err;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync_rx (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_d    (i_RX_Serial),
    .o_q    (w_rx_s)
  );

  assign w_mid     = (r_clk_cnt == CNT_MID);
  assign w_bit_end = (r_clk_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_state_nxt = START;
      START:   if (w_mid) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:  if (w_bit_end) w_state_nxt = STOP;
`endif
      STOP:    if (w_bit_end) w_state_nxt = CLEANUP;
      CLEANUP: if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit timing: the counter restarts on every state change and every bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_cnt <= '0;
      r_idx     <= 3'd0;
    end else begin
      if ((w_state_nxt != r_state) || w_bit_end ||
          (r_state == IDLE) || (r_state == CLEANUP)) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      if (r_state != DATA) begin
        r_idx <= 3'd0;
      end else if (w_bit_end) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == DATA) && w_bit_end) begin
      r_shift[r_idx] <= w_rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic r_par_strb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_err <= 1'b0;
    end else if ((r_state == PARITY) && w_bit_end) begin
      r_par_err <= (^r_shift) ^ w_rx_s ^ PARITY_ODD[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_strb <= 1'b0;
    end else begin
      r_par_strb <= (r_state == STOP) && w_bit_end && w_rx_s && r_par_err;
    end
  end

  assign w_par_err    = r_par_err;
  assign o_Parity_Err = r_par_strb;
`else
  // The AND with 0 keeps PARITY_ODD referenced in the 8N1 build.
  assign w_par_err    = PARITY_ODD[0] & 1'b0;
  assign o_Parity_Err = 1'b0;
`endif

  // Frame outcome: stop sample decides exactly one strobe, visible the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      r_byte      <= 8'h00;
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      if ((r_state == STOP) && w_bit_end) begin
        if (!w_rx_s) begin
          r_frame_err <= 1'b1;
        end else if (!w_par_err) begin
          r_dv   <= 1'b1;
          r_byte <= r_shift;
        end
      end
    end
  end

  assign o_RX_DV     = r_dv;
  assign o_RX_Byte   = r_byte;
  assign o_Frame_Err = r_frame_err;
  assign o_RX_Active = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clk/bit with a byte scoreboard.
module tb_uart_rx_byte;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rx;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  int checks;
  int errors;
  int dv_cnt;
  int fe_cnt;
  int pe_cnt;
  logic [7:0] exp_q[$];

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (rx),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_Active (o_RX_Active),
    .o_Frame_Err (o_Frame_Err),
    .o_Parity_Err(o_Parity_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DV strobe pops one expected byte.
  always @(negedge clk) begin
    if (rst) begin
      if (o_RX_DV) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          check("dv_unexpected", 32'(o_RX_Byte), 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", 32'(o_RX_Byte), 32'(exp_q.pop_front()));
        end
      end
      if (o_Frame_Err) fe_cnt++;
      if (o_Parity_Err) pe_cnt++;
      if ((32'(o_RX_DV) + 32'(o_Frame_Err) + 32'(o_Parity_Err)) > 1) begin
        check("strobe_excl", 32'(o_RX_DV) + 32'(o_Frame_Err) + 32'(o_Parity_Err), 32'd1);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0, fe0, pe0;
    checks = 0; errors = 0; dv_cnt = 0; fe_cnt = 0; pe_cnt = 0;
    rx  = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_dv",     32'(o_RX_DV),      32'd0);
    check("rst_byte",   32'(o_RX_Byte),    32'd0);
    check("rst_active", 32'(o_RX_Active),  32'd0);
    check("rst_fe",     32'(o_Frame_Err),  32'd0);
    check("rst_pe",     32'(o_Parity_Err), 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte 8'hA5 (even parity bit = 0).
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t1_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("t1_pe_count", 32'(pe_cnt - pe0), 32'd0);
    check("t1_active",   32'(o_RX_Active),  32'd0);
    check("t1_byte",     32'(o_RX_Byte),    32'hA5);

    // Back-to-back 8'h00 then 8'hFF.
    dv0 = dv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t2_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("t2_q_empty",  32'(exp_q.size()), 32'd0);

    // 2-clk glitch on an idle line.
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t3_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("t3_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("t3_active",   32'(o_RX_Active),  32'd0);
    check("t3_byte",     32'(o_RX_Byte),    32'hFF);

    // Frame error on 8'h3C, line held low, then recovery with 8'h12.
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t4_active_low_line", 32'(o_RX_Active), 32'd1);
    repeat (10) @(posedge clk);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t4_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("t4_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("t4_pe_count", 32'(pe_cnt - pe0), 32'd0);
    check("t4_active",   32'(o_RX_Active),  32'd0);
    dv0 = dv_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_next_dv", 32'(dv_cnt - dv0), 32'd1);

    // Reset after data bit 3 of 8'h5A, then receive 8'h81.
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b0);
    rst = 1'b0;
    #1;
    check("t5_rst_active", 32'(o_RX_Active),  32'd0);
    check("t5_rst_byte",   32'(o_RX_Byte),    32'd0);
    check("t5_rst_dv",     32'(o_RX_DV),      32'd0);
    check("t5_rst_fe",     32'(o_Frame_Err),  32'd0);
    check("t5_rst_pe",     32'(o_Parity_Err), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_strobe", 32'(dv_cnt - dv0 + fe_cnt - fe0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("t5_byte",     32'(o_RX_Byte),    32'h81);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 has three ones, so parity bit 1 is correct.
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_good_dv", 32'(dv_cnt - dv0), 32'd1);
    check("t6_good_pe", 32'(pe_cnt - pe0), 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_bad_dv", 32'(dv_cnt - dv0), 32'd0);
    check("t6_bad_pe", 32'(pe_cnt - pe0), 32'd1);
    check("t6_bad_fe", 32'(fe_cnt - fe0), 32'd0);
`else
    check("pe_never", 32'(pe_cnt), 32'd0);
`endif

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
